// File: rtl/collision_ctrl_pkg.sv
// Shared game constants and types for the frog/car collision path.
// Screen geometry, sprite hitbox sizes, life/grace defaults and the controller FSM encoding.
package collision_ctrl_pkg;

  localparam int COORD_W      = 10;
  localparam int GAME_WIDTH   = 640;
  localparam int GAME_HEIGHT  = 480;

  localparam int DEF_CAR_W        = 32;
  localparam int DEF_CAR_H        = 32;
  localparam int DEF_FROG_W       = 32;
  localparam int DEF_FROG_H       = 32;
  localparam int DEF_LIVES_INIT   = 3;
  localparam int DEF_GRACE_FRAMES = 60;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_RESOLVE
  } state_e;

endpackage

// File: rtl/collision_ctrl_rect_overlap.sv
// Combinational axis-aligned bounding-box overlap test between rectangle A and rectangle B.
// Right/bottom edges are computed one bit wider than the coordinates, so boxes never wrap.
module rect_overlap
  import collision_ctrl_pkg::*;
#(
  parameter int A_W = DEF_FROG_W,
  parameter int A_H = DEF_FROG_H,
  parameter int B_W = DEF_CAR_W,
  parameter int B_H = DEF_CAR_H
) (
  input  logic [COORD_W-1:0] a_x_i,
  input  logic [COORD_W-1:0] a_y_i,
  input  logic [COORD_W-1:0] b_x_i,
  input  logic [COORD_W-1:0] b_y_i,
  output logic               overlap_o
);

  logic [COORD_W:0] a_x_e, a_y_e, b_x_e, b_y_e;
  logic [COORD_W:0] a_r, a_b, b_r, b_b;

  assign a_x_e = {1'b0, a_x_i};
  assign a_y_e = {1'b0, a_y_i};
  assign b_x_e = {1'b0, b_x_i};
  assign b_y_e = {1'b0, b_y_i};

  assign a_r = a_x_e + (COORD_W+1)'(A_W);
  assign a_b = a_y_e + (COORD_W+1)'(A_H);
  assign b_r = b_x_e + (COORD_W+1)'(B_W);
  assign b_b = b_y_e + (COORD_W+1)'(B_H);

  // Strict compares: boxes that merely touch edge-to-edge do not overlap.
  assign overlap_o = (a_x_e < b_r) && (b_x_e < a_r) &&
                     (a_y_e < b_b) && (b_y_e < a_b);

endmodule

// File: rtl/collision_ctrl.sv
// Per-frame frog-vs-car collision scanner: snapshots positions at frame start, checks one car
// per clock, then resolves lives, post-hit grace and game-over.
module collision_ctrl
  import collision_ctrl_pkg::*;
#(
  parameter int NUM_CARS     = 4,
  parameter int CAR_W        = DEF_CAR_W,
  parameter int CAR_H        = DEF_CAR_H,
  parameter int FROG_W       = DEF_FROG_W,
  parameter int FROG_H       = DEF_FROG_H,
  parameter int LIVES_INIT   = DEF_LIVES_INIT,
  parameter int GRACE_FRAMES = DEF_GRACE_FRAMES
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  input  logic                        i_Frame_Start,
  input  logic                        i_Game_Restart,
  input  logic [COORD_W-1:0]          i_Frog_X,
  input  logic [COORD_W-1:0]          i_Frog_Y,
  input  logic [COORD_W*NUM_CARS-1:0] i_Cars_X,
  input  logic [COORD_W*NUM_CARS-1:0] i_Cars_Y,
  output logic                        o_Hit,
  output logic [3:0]                  o_Lives,
  output logic                        o_Game_Over,
  output logic                        o_Busy
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_CARS - 1);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       hit_any_q, hit_any_d;
  logic [7:0] grace_q, grace_d;
  logic [3:0] lives_q, lives_d;
  logic       game_over_q, game_over_d;
  logic       hit_q, hit_d;
  coord_t     frog_x_q, frog_x_d;
  coord_t     frog_y_q, frog_y_d;
  coord_t     car_x_q [NUM_CARS];
  coord_t     car_x_d [NUM_CARS];
  coord_t     car_y_q [NUM_CARS];
  coord_t     car_y_d [NUM_CARS];

  coord_t     sel_x, sel_y;
  logic       overlap;

  // Equality-compare mux keeps the 4-bit index independent of the array depth.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int k = 0; k < NUM_CARS; k++) begin
      if (idx_q == 4'(k)) begin
        sel_x = car_x_q[k];
        sel_y = car_y_q[k];
      end
    end
  end

  rect_overlap #(
    .A_W (FROG_W),
    .A_H (FROG_H),
    .B_W (CAR_W),
    .B_H (CAR_H)
  ) u_overlap (
    .a_x_i     (frog_x_q),
    .a_y_i     (frog_y_q),
    .b_x_i     (sel_x),
    .b_y_i     (sel_y),
    .overlap_o (overlap)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    hit_any_d   = hit_any_q;
    grace_d     = grace_q;
    lives_d     = lives_q;
    game_over_d = game_over_q;
    hit_d       = 1'b0;
    frog_x_d    = frog_x_q;
    frog_y_d    = frog_y_q;
    car_x_d     = car_x_q;
    car_y_d     = car_y_q;

    if (i_Game_Restart) begin
      state_d     = ST_IDLE;
      idx_d       = '0;
      hit_any_d   = 1'b0;
      grace_d     = '0;
      lives_d     = 4'(LIVES_INIT);
      game_over_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_Frame_Start) begin
            frog_x_d = i_Frog_X;
            frog_y_d = i_Frog_Y;
            for (int k = 0; k < NUM_CARS; k++) begin
              car_x_d[k] = i_Cars_X[COORD_W*k +: COORD_W];
              car_y_d[k] = i_Cars_Y[COORD_W*k +: COORD_W];
            end
            if (grace_q != '0) grace_d = grace_q - 8'd1;
            hit_any_d = 1'b0;
            idx_d     = '0;
            state_d   = ST_SCAN;
          end
        end
        ST_SCAN: begin
          hit_any_d = hit_any_q | overlap;
          idx_d     = idx_q + 4'd1;
          if (idx_q == LAST_IDX) state_d = ST_RESOLVE;
        end
        ST_RESOLVE: begin
          if (hit_any_q && (grace_q == '0) && !game_over_q) begin
            hit_d   = 1'b1;
            lives_d = lives_q - 4'd1;
            grace_d = 8'(GRACE_FRAMES);
            if (lives_q == 4'd1) game_over_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: the snapshot array is small, so it is cleared on reset like any other register
  // rather than left uninitialised as a RAM would be.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      hit_any_q   <= 1'b0;
      grace_q     <= '0;
      lives_q     <= 4'(LIVES_INIT);
      game_over_q <= 1'b0;
      hit_q       <= 1'b0;
      frog_x_q    <= '0;
      frog_y_q    <= '0;
      for (int k = 0; k < NUM_CARS; k++) begin
        car_x_q[k] <= '0;
        car_y_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples its pre-edge next state.
      state_q     <= state_d;
      idx_q       <= idx_d;
      hit_any_q   <= hit_any_d;
      grace_q     <= grace_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
      hit_q       <= hit_d;
      frog_x_q    <= frog_x_d;
      frog_y_q    <= frog_y_d;
      car_x_q     <= car_x_d;
      car_y_q     <= car_y_d;
    end
  end

  assign o_Hit       = hit_q;
  assign o_Lives     = lives_q;
  assign o_Game_Over = game_over_q;
  assign o_Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_collision_ctrl.sv
// Directed bench for collision_ctrl: latency, edge adjacency, grace window, game-over,
// restart priority, no-wrap, multi-car overlap, snapshot isolation and async reset.
module tb_collision_ctrl;

  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            frame_start;
  logic            restart;
  logic [9:0]      frog_x, frog_y;
  logic [9:0]      cx [NC];
  logic [9:0]      cy [NC];
  logic [10*NC-1:0] cars_x, cars_y;
  logic            hit, game_over, busy;
  logic [3:0]      lives;

  int total = 0;
  int bad   = 0;
  int hits, busy_n, acc;

  always #5 clk = ~clk;

  always_comb begin
    cars_x = '0;
    cars_y = '0;
    for (int k = 0; k < NC; k++) begin
      cars_x[10*k +: 10] = cx[k];
      cars_y[10*k +: 10] = cy[k];
    end
  end

  collision_ctrl #(.NUM_CARS(NC)) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Frame_Start  (frame_start),
    .i_Game_Restart (restart),
    .i_Frog_X       (frog_x),
    .i_Frog_Y       (frog_y),
    .i_Cars_X       (cars_x),
    .i_Cars_Y       (cars_y),
    .o_Hit          (hit),
    .o_Lives        (lives),
    .o_Game_Over    (game_over),
    .o_Busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cars_far;
    for (int k = 0; k < NC; k++) begin
      cx[k] = 10'd400;
      cy[k] = 10'd0;
    end
  endtask

  // One strobed frame; samples 12 post-edge points starting right after E0.
  task automatic do_frame(output int h, output int b);
    h = 0;
    b = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (busy) b++;
      if (hit) h++;
      tick();
    end
  endtask

  task automatic do_restart;
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    restart = 1'b0;
    frog_x = 10'd100;
    frog_y = 10'd200;
    cars_far();
    #3;
    check("rst_lives", lives, 3);
    check("rst_go", game_over, 0);
    check("rst_busy", busy, 0);
    check("rst_hit", hit, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic hit with explicit latency and busy length.
    cx[0] = 10'd90;
    cy[0] = 10'd200;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    busy_n = 0;
    hits = 0;
    for (int c = 0; c < 5; c++) begin
      if (busy) busy_n++;
      if (hit) hits++;
      tick();
    end
    check("lat_hit_pre", hits, 0);
    check("lat_hit_e5", hit, 1);
    check("lat_busy_e5", busy, 0);
    check("lat_busy_cycles", busy_n, 5);
    check("lat_lives", lives, 2);
    tick();
    check("lat_hit_e6", hit, 0);

    // Grace window: frames F+1..F+59 blocked, F+60 hits.
    acc = 0;
    for (int f = 1; f < 60; f++) begin
      do_frame(hits, busy_n);
      acc += hits;
    end
    check("grace_blocked", acc, 0);
    check("grace_lives_hold", lives, 2);
    do_frame(hits, busy_n);
    check("grace_f60_hit", hits, 1);
    check("grace_f60_lives", lives, 1);

    do_restart();
    check("restart1_lives", lives, 3);

    // Edge adjacency.
    cx[0] = 10'd68;
    do_frame(hits, busy_n);
    check("touch_nohit", hits, 0);
    cx[0] = 10'd69;
    do_frame(hits, busy_n);
    check("adj69_hit", hits, 1);
    check("adj69_lives", lives, 2);

    // Run to game over: hits at frames 0, 60, 120.
    do_restart();
    cx[0] = 10'd90;
    acc = 0;
    for (int f = 0; f < 121; f++) begin
      do_frame(hits, busy_n);
      acc += hits;
    end
    check("go_hits", acc, 3);
    check("go_lives", lives, 0);
    check("go_flag", game_over, 1);
    acc = 0;
    for (int f = 0; f < 3; f++) begin
      do_frame(hits, busy_n);
      acc += hits;
    end
    check("go_no_more_hits", acc, 0);
    check("go_scan_runs", busy_n, 5);
    check("go_lives_hold", lives, 0);
    do_restart();
    check("go_restart_lives", lives, 3);
    check("go_restart_flag", game_over, 0);

    // Restart sampled at E2 while overlapping.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("midrst_busy", busy, 0);
    hits = 0;
    for (int c = 0; c < 8; c++) begin
      if (hit) hits++;
      tick();
    end
    check("midrst_hits", hits, 0);
    check("midrst_lives", lives, 3);

    // Restart and strobe together: no scan.
    restart = 1'b1;
    frame_start = 1'b1;
    tick();
    restart = 1'b0;
    frame_start = 1'b0;
    check("both_busy", busy, 0);
    hits = 0;
    for (int c = 0; c < 8; c++) begin
      if (hit) hits++;
      tick();
    end
    check("both_hits", hits, 0);

    // No wrap at the right screen edge.
    cars_far();
    cy[0] = 10'd400;
    frog_x = 10'd0;
    cx[0] = 10'd630;
    cy[0] = 10'd200;
    do_frame(hits, busy_n);
    check("nowrap_hits", hits, 0);

    // Snapshot isolation: car moves into the frog after E0.
    cars_far();
    frog_x = 10'd100;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cx[0] = 10'd90;
    cy[0] = 10'd200;
    hits = 0;
    for (int c = 0; c < 12; c++) begin
      if (hit) hits++;
      tick();
    end
    check("snap_hits", hits, 0);
    check("snap_lives", lives, 3);

    // Two overlapping cars cost one life.
    cars_far();
    cx[1] = 10'd110;
    cy[1] = 10'd210;
    cx[3] = 10'd95;
    cy[3] = 10'd190;
    do_frame(hits, busy_n);
    check("multi_hits", hits, 1);
    check("multi_lives", lives, 2);

    // Asynchronous reset mid-scan.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    check("arst_pre_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_lives", lives, 3);
    check("arst_busy", busy, 0);
    check("arst_hit", hit, 0);
    check("arst_go", game_over, 0);
    rst = 1'b0;
    tick();
    check("arst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
